// File: rtl/channel_readout_packer_pkg.sv
// channel_readout_packer_pkg: shared FSM states, frame tags and word-format widths.
package channel_readout_packer_pkg;
   localparam int TAG_W = 4;
   localparam int WORD_W = 16;
   localparam logic [TAG_W-1:0] TAG_HDR = 4'hA;
   localparam logic [TAG_W-1:0] TAG_TRL = 4'hF;
   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_TSTAMP, S_READ, S_DRAIN, S_TRAILER, S_DONE
   } state_t;
endpackage

// File: rtl/channel_readout_packer_fifo.sv
// readout_fifo: synchronous show-ahead FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module readout_fifo
   import channel_readout_packer_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic [WORD_W-1:0] pop_data,
   output logic              valid,
   output logic [AW:0]       count
);
   logic [WORD_W-1:0] mem [2**AW];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic wr_en, rd_en;
   assign valid = count != '0;
   assign rd_en = pop & valid;
   assign wr_en = push & (!count[AW] | rd_en);
   assign pop_data = valid ? mem[rd_ptr] : '0;
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= push_data;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_en);
         rd_ptr <= rd_ptr + AW'(rd_en);
         count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
endmodule

// File: rtl/channel_readout_packer.sv
// channel_readout_packer: reads a ringbuffer window and frames it as header/[timestamp]/samples/XOR trailer.
// Optional timestamp word enabled by CHANNEL_READOUT_PACKER_TIMESTAMP_EN.
module channel_readout_packer
   import channel_readout_packer_pkg::*;
#(
   parameter int SIZE = 12,
   parameter int WIDTH = 12,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_AW = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       ch_id,
   input  logic [SIZE-1:0]  start_addr,
   input  logic [SIZE-1:0]  how_many,
   output logic             read_request,
   output logic [SIZE-1:0]  read_address,
   input  logic [WIDTH-1:0] sample_in,
   output logic [15:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             spi_done
);
   localparam int DEPTH = 1 << FIFO_AW;
   state_t state;
   logic [3:0] ch;
   logic [SIZE-1:0] n, remaining;
   logic [WIDTH-1:0] csum;
   logic [RD_LATENCY-1:0] vld;
   logic [2:0] inflight;
   logic [FIFO_AW:0] count;
   logic full, pop, push, issue, cap, ctl_push;
   logic [WORD_W-1:0] push_data, ts_word;
`ifdef CHANNEL_READOUT_PACKER_TIMESTAMP_EN
   logic [15:0] ts_cnt;
`endif
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + 3'(vld[i]);
   end
   assign full = count[FIFO_AW];
   assign pop = out_valid & out_ready;
   assign cap = vld[RD_LATENCY-1];
   // credit covers reads still in flight so a captured sample always has room
   assign issue = state == S_READ && remaining != '0 && (int'(count) + int'(inflight)) < DEPTH;
   assign ctl_push = !full && (state == S_HEADER || state == S_TSTAMP || state == S_TRAILER);
   assign push = cap | ctl_push;
   assign push_data = cap ? {ch, sample_in} :
                      state == S_HEADER ? {TAG_HDR, n} :
                      state == S_TRAILER ? {TAG_TRL, csum} : ts_word;
   readout_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk(clk),
      .reset_n(reset_n),
      .push(push),
      .push_data(push_data),
      .pop(pop),
      .pop_data(out_data),
      .valid(out_valid),
      .count(count)
   );
`ifdef CHANNEL_READOUT_PACKER_TIMESTAMP_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ts_cnt <= '0;
         ts_word <= '0;
      end else begin
         ts_cnt <= ts_cnt + 16'd1;
         if (state == S_IDLE && start) ts_word <= ts_cnt;
      end
`else
   assign ts_word = '0;
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= S_IDLE;
         ch <= '0;
         n <= '0;
         remaining <= '0;
         csum <= '0;
         vld <= '0;
         read_request <= 1'b0;
         read_address <= '0;
         busy <= 1'b0;
         spi_done <= 1'b0;
      end else begin
         spi_done <= 1'b0;
         vld[0] <= issue;
         for (int i = 1; i < RD_LATENCY; i++) vld[i] <= vld[i-1];
         if (cap) csum <= csum ^ sample_in;
         case (state)
            S_IDLE:
               if (start) begin
                  ch <= ch_id;
                  n <= how_many;
                  remaining <= how_many;
                  read_address <= start_addr;
                  csum <= '0;
                  busy <= 1'b1;
                  read_request <= how_many != '0;
                  state <= S_HEADER;
               end
`ifdef CHANNEL_READOUT_PACKER_TIMESTAMP_EN
            S_HEADER: if (!full) state <= S_TSTAMP;
`else
            S_HEADER: if (!full) state <= S_READ;
`endif
            S_TSTAMP: if (!full) state <= S_READ;
            S_READ:
               if (remaining == '0) state <= S_DRAIN;
               else if (issue) begin
                  read_address <= read_address + 1'b1;
                  remaining <= remaining - 1'b1;
               end
            S_DRAIN:
               if (inflight == '0) begin
                  read_request <= 1'b0;
                  state <= S_TRAILER;
               end
            S_TRAILER: if (!full) state <= S_DONE;
            S_DONE:
               // trailer is the only word left; its handshake ends the frame
               if (pop && count == (FIFO_AW+1)'(1)) begin
                  spi_done <= 1'b1;
                  busy <= 1'b0;
                  state <= S_IDLE;
               end
            default: state <= S_IDLE;
         endcase
      end
endmodule
